// File: rtl/digdug_spatr_buffer.sv
// Sprite attribute buffer: CPU-written shadow planes packed once per vblank into a
// double-buffered 24-bit attribute table. Optional CPU readback: DIGDUG_SPATR_READBACK_EN.
module digdug_spatr_buffer #(
   parameter int NSPR = 64
) (
   input  logic        RCLK,
   input  logic        RESET_N,
   input  logic [8:0]  CPU_AD,
   input  logic        CPU_WR,
   input  logic [7:0]  CPU_DI,
   output logic [7:0]  CPU_DO,
   input  logic        VBLK_TRIG,
   input  logic [6:0]  SPATAD,
   output logic [23:0] SPATDT,
   output logic        BUSY,
   output logic        SWAPPED
);

   localparam logic [7:0] NWORD = 8'(2 * NSPR);
   localparam logic [5:0] LAST  = 6'(NSPR - 1);

   typedef enum logic [2:0] {S_CLR, S_IDLE, S_LOAD, S_W0, S_W1, S_SWAP} state_t;

   state_t      r_state;
   logic [7:0]  r_idx;
   logic        r_front;
   logic        r_pend;
   logic        r_busy;
   logic        r_swapped;
   logic [23:0] r_atr1;
   logic [23:0] r_spatdt;

   logic [15:0] r_p0 [64];
   logic [15:0] r_p1 [64];
   logic [15:0] r_p2 [64];
   logic [15:0] r_p0_rd;
   logic [15:0] r_p1_rd;
   logic [15:0] r_p2_rd;
   logic [23:0] r_tbl [256];

   logic [1:0]  w_cpu_plane;
   logic [5:0]  w_cpu_spr;
   logic        w_cpu_byte;
   logic [5:0]  w_sh_addr;
   logic [23:0] w_atr0;
   logic [23:0] w_atr1;
   logic        w_tbl_we;
   logic [7:0]  w_tbl_wa;
   logic [23:0] w_tbl_wd;
   logic        w_unused_bits;

   assign w_cpu_plane = CPU_AD[8:7];
   assign w_cpu_spr   = CPU_AD[6:1];
   assign w_cpu_byte  = CPU_AD[0];

   // The engine reads one sprite ahead during W0/W1 so the next W0 finds its data ready.
   always_comb begin
      w_sh_addr = r_idx[5:0];
      if (r_state == S_W0 || r_state == S_W1)
         w_sh_addr = r_idx[5:0] + 6'd1;
   end

   always_ff @(posedge RCLK) begin
      if (CPU_WR) begin
         case (w_cpu_plane)
            2'd0: if (w_cpu_byte) r_p0[w_cpu_spr][15:8] <= CPU_DI; else r_p0[w_cpu_spr][7:0] <= CPU_DI;
            2'd1: if (w_cpu_byte) r_p1[w_cpu_spr][15:8] <= CPU_DI; else r_p1[w_cpu_spr][7:0] <= CPU_DI;
            2'd2: if (w_cpu_byte) r_p2[w_cpu_spr][15:8] <= CPU_DI; else r_p2[w_cpu_spr][7:0] <= CPU_DI;
            default: ;
         endcase
      end
      r_p0_rd <= r_p0[w_sh_addr];
      r_p1_rd <= r_p1[w_sh_addr];
      r_p2_rd <= r_p2[w_sh_addr];
   end

   assign w_atr0 = {6'b0, r_p2_rd[1], r_p2_rd[0], r_p1_rd[7:0], r_p0_rd[7:0]};
   assign w_atr1 = {6'b0, r_p2_rd[9], 1'b0, r_p1_rd[15:8], 2'b0, r_p0_rd[13:8]};
   assign w_unused_bits = ^{r_p0_rd[15:14], r_p2_rd[15:10], r_p2_rd[8], r_p2_rd[7:2]};

   always_comb begin
      w_tbl_we = 1'b0;
      w_tbl_wa = r_idx;
      w_tbl_wd = 24'h000000;
      case (r_state)
         S_CLR: begin
            w_tbl_we = 1'b1;
            w_tbl_wd = r_idx[0] ? 24'h020000 : 24'h000000;
         end
         S_W0: begin
            w_tbl_we = 1'b1;
            w_tbl_wa = {~r_front, r_idx[5:0], 1'b0};
            w_tbl_wd = w_atr0;
         end
         S_W1: begin
            w_tbl_we = 1'b1;
            w_tbl_wa = {~r_front, r_idx[5:0], 1'b1};
            w_tbl_wd = r_atr1;
         end
         default: ;
      endcase
      if (!RESET_N)
         w_tbl_we = 1'b0;
   end

   always_ff @(posedge RCLK) begin
      if (w_tbl_we)
         r_tbl[w_tbl_wa] <= w_tbl_wd;
      if (!RESET_N)
         r_spatdt <= 24'h000000;
      else if ({1'b0, SPATAD} >= NWORD)
         r_spatdt <= 24'h000000;
      else
         r_spatdt <= r_tbl[{r_front, SPATAD}];
   end

   always_ff @(posedge RCLK) begin
      if (!RESET_N) begin
         r_state   <= S_CLR;
         r_idx     <= 8'd0;
         r_front   <= 1'b0;
         r_pend    <= 1'b0;
         r_busy    <= 1'b1;
         r_swapped <= 1'b0;
         r_atr1    <= 24'h000000;
      end else begin
         r_swapped <= 1'b0;
         // Triggers arriving while busy coalesce into a single pending copy.
         if (VBLK_TRIG && r_state != S_IDLE)
            r_pend <= 1'b1;
         case (r_state)
            S_CLR: begin
               r_idx <= r_idx + 8'd1;
               if (r_idx == 8'hFF) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_idx   <= 8'd0;
               end
            end
            S_IDLE: begin
               if (VBLK_TRIG || r_pend) begin
                  r_state <= S_LOAD;
                  r_idx   <= 8'd0;
                  r_pend  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: r_state <= S_W0;
            S_W0: begin
               r_atr1  <= w_atr1;
               r_state <= S_W1;
            end
            S_W1: begin
               if (r_idx[5:0] == LAST) begin
                  r_state   <= S_SWAP;
                  r_swapped <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_state <= S_W0;
               end
            end
            S_SWAP: begin
               r_front <= ~r_front;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_CLR;
         endcase
      end
   end

`ifdef DIGDUG_SPATR_READBACK_EN
   logic [7:0] r_cpu_do;
   logic [15:0] w_rb_word;

   always_comb begin
      w_rb_word = 16'hFFFF;
      case (w_cpu_plane)
         2'd0: w_rb_word = r_p0[w_cpu_spr];
         2'd1: w_rb_word = r_p1[w_cpu_spr];
         2'd2: w_rb_word = r_p2[w_cpu_spr];
         default: w_rb_word = 16'hFFFF;
      endcase
   end

   always_ff @(posedge RCLK) begin
      if (!RESET_N)
         r_cpu_do <= 8'h00;
      else
         r_cpu_do <= w_cpu_byte ? w_rb_word[15:8] : w_rb_word[7:0];
   end

   assign CPU_DO = r_cpu_do;
`else
   assign CPU_DO = 8'h00;
`endif

   assign SPATDT  = r_spatdt;
   assign BUSY    = r_busy;
   assign SWAPPED = r_swapped;

endmodule

// File: tb/tb_digdug_spatr_buffer.sv
// Self-checking bench for digdug_spatr_buffer: clear, copy timing, tear-free reads,
// trigger coalescing, mid-copy updates, reset mid-copy and optional CPU readback.
module tb_digdug_spatr_buffer;

   logic        RCLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [8:0]  CPU_AD = '0;
   logic        CPU_WR = 1'b0;
   logic [7:0]  CPU_DI = '0;
   logic [7:0]  CPU_DO;
   logic        VBLK_TRIG = 1'b0;
   logic [6:0]  SPATAD = '0;
   logic [23:0] SPATDT;
   logic        BUSY;
   logic        SWAPPED;

   int n_checks = 0;
   int n_errors = 0;
   logic [23:0] exp_q [$];
   logic [15:0] m_sh [3][64];

   typedef struct {
      logic [6:0]  addr;
      logic [23:0] exp;
   } vec_t;

   digdug_spatr_buffer #(.NSPR(64)) dut (
      .RCLK(RCLK), .RESET_N(RESET_N), .CPU_AD(CPU_AD), .CPU_WR(CPU_WR),
      .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .VBLK_TRIG(VBLK_TRIG), .SPATAD(SPATAD),
      .SPATDT(SPATDT), .BUSY(BUSY), .SWAPPED(SWAPPED)
   );

   // clock / reset
   always #5 RCLK = ~RCLK;

   task automatic tick();
      @(posedge RCLK);
      #1;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      VBLK_TRIG = 1'b0;
      CPU_WR = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
   endtask

   // checking
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // model of the packing, derived from the plane layout
   function automatic logic [23:0] atr(input logic [6:0] a);
      logic [5:0] s;
      s = a[6:1];
      if (!a[0])
         return {6'b0, m_sh[2][s][1], m_sh[2][s][0], m_sh[1][s][7:0], m_sh[0][s][7:0]};
      else
         return {6'b0, m_sh[2][s][9], 1'b0, m_sh[1][s][15:8], 2'b0, m_sh[0][s][13:8]};
   endfunction

   // drivers
   task automatic cpu_wr(input int plane, input int spr, input int b, input logic [7:0] d);
      CPU_AD = {2'(plane), 6'(spr), 1'(b)};
      CPU_DI = d;
      CPU_WR = 1'b1;
      tick();
      CPU_WR = 1'b0;
      if (plane < 3) begin
         if (b != 0) m_sh[plane][spr][15:8] = d;
         else        m_sh[plane][spr][7:0]  = d;
      end
   endtask

   task automatic pulse_vblk();
      VBLK_TRIG = 1'b1;
      tick();
      VBLK_TRIG = 1'b0;
   endtask

   task automatic read_word(input string name, input logic [6:0] a, input logic [23:0] exp);
      SPATAD = a;
      exp_q.push_back(exp);
      tick();
      chk(name, {8'h0, SPATDT}, {8'h0, exp_q.pop_front()});
   endtask

   task automatic wait_swap(input string name);
      int cnt;
      cnt = 0;
      while (SWAPPED !== 1'b1 && cnt < 400) begin
         tick();
         cnt++;
      end
      if (cnt >= 400) chk({name, "_timeout"}, 32'(cnt), 32'd0);
   endtask

   initial begin
      vec_t clr_vecs [6];
      logic [6:0] post_addrs [8];
      vec_t post_vecs [8];
      int cnt;
      logic held;
      logic [23:0] old_w;
      int rises, swaps, low_run;
      logic prev_busy;

      clr_vecs[0] = '{7'h01, 24'h020000};
      clr_vecs[1] = '{7'h00, 24'h000000};
      clr_vecs[2] = '{7'h7F, 24'h020000};
      clr_vecs[3] = '{7'h7E, 24'h000000};
      clr_vecs[4] = '{7'h41, 24'h020000};
      clr_vecs[5] = '{7'h22, 24'h000000};
      post_addrs = '{7'd10, 7'd11, 7'd0, 7'd1, 7'd63, 7'd64, 7'd126, 7'd127};

      // 1. reset and clear
      do_reset();
      chk("rst_busy", {31'b0, BUSY}, 32'd1);
      chk("rst_swapped", {31'b0, SWAPPED}, 32'd0);
      chk("rst_spatdt", {8'h0, SPATDT}, 32'd0);
      chk("rst_cpu_do", {24'h0, CPU_DO}, 32'd0);
      cnt = 0;
      while (BUSY === 1'b1 && cnt < 400) begin
         tick();
         cnt++;
      end
      chk("clr_busy_cycles", 32'(cnt), 32'd256);
      for (int i = 0; i < 6; i++)
         read_word("clr_word", clr_vecs[i].addr, clr_vecs[i].exp);

      // fill all shadow planes with random content
      for (int s = 0; s < 64; s++)
         for (int p = 0; p < 3; p++)
            for (int b = 0; b < 2; b++)
               cpu_wr(p, s, b, 8'($urandom_range(0, 255)));
      cpu_wr(0, 5, 0, 8'h0C);
      cpu_wr(0, 5, 1, 8'h2A);
      cpu_wr(1, 5, 0, 8'h40);
      cpu_wr(1, 5, 1, 8'h90);
      cpu_wr(2, 5, 0, 8'h03);
      cpu_wr(2, 5, 1, 8'h00);
      cpu_wr(3, 5, 0, 8'hFF);

      // 2/3. copy timing and tear-free reads of address 10
      SPATAD = 7'd10;
      tick();
      pulse_vblk();
      cnt = 1;
      held = 1'b1;
      while (SWAPPED !== 1'b1 && cnt < 300) begin
         if (SPATDT !== 24'h000000) held = 1'b0;
         tick();
         cnt++;
      end
      chk("swap_latency", 32'(cnt), 32'd130);
      if (SPATDT !== 24'h000000) held = 1'b0;
      chk("old_held_until_swap", {31'b0, held}, 32'd1);
      tick();
      tick();
      chk("new_after_swap", {8'h0, SPATDT}, 32'h03400C);
      read_word("spr5_atr0", 7'd10, 24'h03400C);
      read_word("spr5_atr1", 7'd11, 24'h00902A);
      for (int i = 0; i < 8; i++) post_vecs[i] = '{post_addrs[i], atr(post_addrs[i])};
      for (int i = 0; i < 8; i++)
         read_word("copy_word", post_vecs[i].addr, post_vecs[i].exp);

      // 6. CPU readback
      cpu_wr(1, 63, 1, 8'hA5);
      tick();
`ifdef DIGDUG_SPATR_READBACK_EN
      chk("readback_p1", {24'h0, CPU_DO}, 32'hA5);
      CPU_AD = {2'd3, 6'd7, 1'b0};
      tick();
      chk("readback_p3", {24'h0, CPU_DO}, 32'hFF);
`else
      chk("readback_off", {24'h0, CPU_DO}, 32'h00);
`endif

      // 5. CPU write during a copy plus a pending trigger
      cpu_wr(1, 0, 1, 8'h11);
      pulse_vblk();
      for (int i = 0; i < 20; i++) tick();
      old_w = atr(7'd1);
      cpu_wr(1, 0, 1, 8'h77);
      pulse_vblk();
      chk("busy_during_copy", {31'b0, BUSY}, 32'd1);
      wait_swap("first_swap");
      tick();
      read_word("frame1_old_x", 7'd1, old_w);
      wait_swap("second_swap");
      tick();
      read_word("frame2_new_x", 7'd1, atr(7'd1));
      chk("frame2_x_byte", {24'h0, SPATDT[15:8]}, 32'h77);

      // reset mid-copy, then 4. coalesced triggers during CLR
      pulse_vblk();
      for (int i = 0; i < 30; i++) tick();
      do_reset();
      rises = 0;
      swaps = 0;
      low_run = 0;
      prev_busy = 1'b1;
      for (int i = 0; i < 700; i++) begin
         VBLK_TRIG = (i == 50 || i == 60);
         tick();
         if (BUSY && !prev_busy) rises++;
         if (!BUSY && rises == 0) low_run++;
         if (SWAPPED) swaps++;
         prev_busy = BUSY;
      end
      VBLK_TRIG = 1'b0;
      chk("coalesce_copies", 32'(rises), 32'd1);
      chk("coalesce_swaps", 32'(swaps), 32'd1);
      chk("copy_starts_after_clr", 32'(low_run), 32'd1);
      read_word("after_coalesce_w10", 7'd10, atr(7'd10));
      read_word("after_coalesce_w1", 7'd1, atr(7'd1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
